sdm2_bitstream_tx: RTL and testbench

Second-order delta-sigma modulator that turns 16-bit unsigned PCM samples into a 1-bit density-coded bitstream plus bit clock. It is the transmit end of the team's sigma-delta link: it drives the same `mclk1`/`mdata1` style interface that the sinc3 decimators consume. It is used both as a bitstream DAC and as the stimulus source for decimator loopback tests. Each accepted sample is held for OSR bit periods, and samples are double-buffered behind a valid/ready handshake.

---
 rtl/sdm2_bitstream_tx.sv | 165 ++++++++++++++++
 tb/tb_sdm2_bitstream_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm2_bitstream_tx.sv
// Second-order delta-sigma modulator: 16-bit unsigned PCM in, 1-bit density stream plus bit clock out.
// Define SDM2_DITHER_EN to add a 16-bit LFSR dither term ahead of the quantizer.
module sdm2_bitstream_tx #(
   parameter logic [15:0] OSR     = 16'd64,
   parameter logic [15:0] CLK_DIV = 16'd4
) (
   input  logic        mclk1,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mclk_out,
   output logic        mdata1,
   output logic        frame_start,
   output logic        underrun,
   output logic        clip
);
   localparam logic signed [25:0] SatHi = 26'sd8388607;
   localparam logic signed [25:0] SatLo = -26'sd8388608;
   localparam logic signed [25:0] FbMag = 26'sd32768;

   logic [15:0]        div_cnt_q, div_cnt_d;
   logic [15:0]        bit_cnt_q, bit_cnt_d;
   logic [15:0]        active_q, active_d;
   logic [15:0]        hold_q, hold_d;
   logic               hold_empty_q, hold_empty_d;
   logic signed [23:0] i1_q, i1_d, i2_q, i2_d;
   logic               mclk_q, mclk_d;
   logic               mdata_q, mdata_d;
   logic               frame_start_q, frame_start_d;
   logic               underrun_q, underrun_d;
   logic               clip_q, clip_d;

   logic               strobe, boundary, transfer, v, clip1, clip2;
   logic signed [25:0] u, dith, fb, i1_ext, i2_ext, quant_in, sum1, sum2, i1_new_ext;
   logic signed [23:0] i1_new, i2_new;

   assign strobe   = (div_cnt_q == CLK_DIV - 16'd1);
   assign boundary = strobe && (bit_cnt_q == OSR - 16'd1);
   assign transfer = in_valid && hold_empty_q;

`ifdef SDM2_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (strobe) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge mclk1) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= lfsr_d;
   end

   assign dith = {{17{lfsr_q[8]}}, lfsr_q[8:0]};
`else
   assign dith = '0;
`endif

   // Loop arithmetic is carried in 26 bits so sums cannot wrap before the 24-bit clamp.
   always_comb begin
      u        = $signed({10'd0, active_q}) - FbMag;
      i1_ext   = {{2{i1_q[23]}}, i1_q};
      i2_ext   = {{2{i2_q[23]}}, i2_q};
      quant_in = i2_ext + dith;
      v        = ~quant_in[25];
      fb       = v ? FbMag : -FbMag;

      sum1  = i1_ext + u - fb;
      clip1 = 1'b0;
      if (sum1 > SatHi) begin
         i1_new = SatHi[23:0];
         clip1  = 1'b1;
      end else if (sum1 < SatLo) begin
         i1_new = SatLo[23:0];
         clip1  = 1'b1;
      end else begin
         i1_new = sum1[23:0];
      end

      i1_new_ext = {{2{i1_new[23]}}, i1_new};
      sum2       = i2_ext + i1_new_ext - fb;
      clip2      = 1'b0;
      if (sum2 > SatHi) begin
         i2_new = SatHi[23:0];
         clip2  = 1'b1;
      end else if (sum2 < SatLo) begin
         i2_new = SatLo[23:0];
         clip2  = 1'b1;
      end else begin
         i2_new = sum2[23:0];
      end
   end

   always_comb begin
      div_cnt_d = strobe ? 16'd0 : div_cnt_q + 16'd1;

      mclk_d = mclk_q;
      if (strobe) mclk_d = 1'b1;
      else if (div_cnt_q == (CLK_DIV >> 1) - 16'd1) mclk_d = 1'b0;

      bit_cnt_d = bit_cnt_q;
      if (strobe) bit_cnt_d = (bit_cnt_q == OSR - 16'd1) ? 16'd0 : bit_cnt_q + 16'd1;

      // Transfer and load never coincide: transfer needs holding empty, load needs it full.
      active_d     = active_q;
      hold_d       = hold_q;
      hold_empty_d = hold_empty_q;
      if (transfer) begin
         hold_d       = in_data;
         hold_empty_d = 1'b0;
      end
      if (boundary && !hold_empty_q) begin
         active_d     = hold_q;
         hold_empty_d = 1'b1;
      end

      i1_d          = strobe ? i1_new : i1_q;
      i2_d          = strobe ? i2_new : i2_q;
      mdata_d       = strobe ? v : mdata_q;
      frame_start_d = boundary;
      underrun_d    = boundary && hold_empty_q;
      clip_d        = strobe && (clip1 || clip2);
   end

   always_ff @(posedge mclk1) begin
      if (reset) begin
         div_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         active_q      <= 16'h8000;
         hold_q        <= '0;
         hold_empty_q  <= 1'b1;
         i1_q          <= '0;
         i2_q          <= '0;
         mclk_q        <= 1'b0;
         mdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         clip_q        <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         active_q      <= active_d;
         hold_q        <= hold_d;
         hold_empty_q  <= hold_empty_d;
         i1_q          <= i1_d;
         i2_q          <= i2_d;
         mclk_q        <= mclk_d;
         mdata_q       <= mdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         clip_q        <= clip_d;
      end
   end

   assign in_ready    = hold_empty_q;
   assign mclk_out    = mclk_q;
   assign mdata1      = mdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
   assign clip        = clip_q;

endmodule

// File: tb/tb_sdm2_bitstream_tx.sv
// Bench for sdm2_bitstream_tx: bit-level reference model feeds a scoreboard that a
// monitor drains on every rising edge of the generated bit clock.
module tb_sdm2_bitstream_tx;
   localparam int Osr    = 64;
   localparam int ClkDiv = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, mclk_out, mdata1, frame_start, underrun, clip;

   always #5 clk = ~clk;

   sdm2_bitstream_tx #(
      .OSR     (16'(Osr)),
      .CLK_DIV (16'(ClkDiv))
   ) dut (
      .mclk1       (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mclk_out    (mclk_out),
      .mdata1      (mdata1),
      .frame_start (frame_start),
      .underrun    (underrun),
      .clip        (clip)
   );

   typedef struct {
      bit v;
      bit fs;
      bit ur;
      bit cl;
   } exp_t;

   exp_t exp_q[$];
   bit   seen_q[$];
   int   total = 0;
   int   bad = 0;
   int   ur_seen = 0;
   int   clip_seen = 0;

   // Reference model state: one step per system cycle, one bit per bit period.
   longint      m_i1, m_i2;
   logic [15:0] m_active, m_hold;
   bit          m_full;
   int          cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h wanted %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d wanted %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   function automatic longint sat24(input longint x, output bit c);
      c = 1'b0;
      if (x > 64'sd8388607) begin
         c = 1'b1;
         return 64'sd8388607;
      end
      if (x < -64'sd8388608) begin
         c = 1'b1;
         return -64'sd8388608;
      end
      return x;
   endfunction

   function automatic int window(input int a, input int n);
      int s = 0;
      if (seen_q.size() < a + n) return -1;
      for (int i = a; i < a + n; i++) s += int'(seen_q[i]);
      return s;
   endfunction

   // Monitor: pops one expectation per rising bit-clock edge; between edges nothing may move.
   bit   prev_mclk = 1'b0;
   logic prev_mdata = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      if (reset) begin
         prev_mclk  = 1'b0;
         prev_mdata = 1'b0;
      end else begin
         if (mclk_out === 1'b1 && !prev_mclk) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_bit: got a bit clock edge, wanted none (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("mdata1", mdata1, e.v);
               check("frame_start", frame_start, e.fs);
               check("underrun", underrun, e.ur);
               check("clip", clip, e.cl);
               seen_q.push_back(mdata1 === 1'b1);
               ur_seen   += int'(underrun === 1'b1);
               clip_seen += int'(clip === 1'b1);
            end
         end else begin
            check("mdata1_stable", mdata1, prev_mdata);
            check("pulses_idle", {frame_start, underrun, clip}, 3'b000);
         end
         prev_mclk  = (mclk_out === 1'b1);
         prev_mdata = mdata1;
      end
   end

   task automatic model_reset();
      m_i1     = 0;
      m_i2     = 0;
      m_active = 16'h8000;
      m_hold   = '0;
      m_full   = 1'b0;
      cyc      = 0;
   endtask

   // One system cycle: drive inputs, check in_ready/mclk_out, advance the model.
   task automatic step(input bit valid, input logic [15:0] data, output bit acc);
      longint u, fb, a, b;
      bit     v, c1, c2, bnd;
      exp_t   x;
      int     k;
      in_valid = valid;
      in_data  = data;
      check("in_ready", in_ready, !m_full);
      check("mclk_out", mclk_out, (cyc >= ClkDiv) && (cyc % ClkDiv < ClkDiv / 2));
      acc = valid && !m_full;
      if (cyc % ClkDiv == ClkDiv - 1) begin
         k    = cyc / ClkDiv;
         bnd  = (k % Osr == Osr - 1);
         v    = (m_i2 >= 0);
         fb   = v ? 64'sd32768 : -64'sd32768;
         u    = longint'(m_active) - 64'sd32768;
         a    = sat24(m_i1 + u - fb, c1);
         b    = sat24(m_i2 + a - fb, c2);
         m_i1 = a;
         m_i2 = b;
         x.v  = v;
         x.fs = bnd;
         x.ur = bnd && !m_full;
         x.cl = c1 || c2;
         exp_q.push_back(x);
         if (bnd && m_full) begin
            m_active = m_hold;
            m_full   = 1'b0;
         end
      end
      if (acc) begin
         m_hold = data;
         m_full = 1'b1;
      end
      cyc++;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, acc);
   endtask

   task automatic run_to(input int c);
      bit acc;
      while (cyc < c) step(1'b0, 16'h0000, acc);
   endtask

   task automatic send(input logic [15:0] data);
      bit acc = 1'b0;
      int n = 0;
      while (!acc && n < 2 * Osr * ClkDiv + 8) begin
         step(1'b1, data, acc);
         n++;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no transfer of %0h, wanted one within %0d cycles",
                  data, n);
      end
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         #1;
      end
      check("rst_mdata1", mdata1, 1'b0);
      check("rst_mclk_out", mclk_out, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_frame_start", frame_start, 1'b0);
      check("rst_underrun", underrun, 1'b0);
      check("rst_clip", clip, 1'b0);
      exp_q.delete();
      seen_q.delete();
      model_reset();
      reset = 1'b0;
   endtask

   int u0, c0;

   initial begin
      @(negedge clk);
      #1;

      // Idle after reset: 1,0,0,1 pattern and one underrun per frame.
      do_reset(3);
      u0 = ur_seen;
      idle(2 * Osr * ClkDiv);
      check_range("idle_ones_f0", window(0, Osr), 32, 32);
      check_range("idle_ones_f1", window(Osr, Osr), 32, 32);
      check_range("idle_underruns", ur_seen - u0, 2, 2);

      // Back-to-back handshake: each second push stalls until the next boundary.
      do_reset(2);
      repeat (4) send(16'hC000);
      repeat (4) send(16'h4000);
      run_to(9 * Osr * ClkDiv + 4);
      check_range("c000_ones", window(Osr, 4 * Osr), 190, 194);
      check_range("4000_ones", window(5 * Osr, 4 * Osr), 62, 66);

      // Random samples within the stable range, random gaps.
      do_reset(2);
      repeat (12) begin
         idle(int'($urandom_range(200, 0)));
         send(16'($urandom_range(16'hE590, 16'h1A00)));
      end
      idle(600);

      // Overload, then recovery at mid-scale.
      do_reset(2);
      c0 = clip_seen;
      send(16'hFFFF);
      run_to(6 * Osr * ClkDiv);
      send(16'h8000);
      run_to(10 * Osr * ClkDiv + 4);
      check_range("overload_clip", clip_seen - c0, 1, 1000000);
      check_range("overload_ones", window(6 * Osr, Osr), 61, 64);
      check_range("recover_ones", window(9 * Osr, Osr), 30, 34);

      // Reset at bit 30 with the holding register full.
      do_reset(2);
      send(16'h6000);
      run_to(Osr * ClkDiv);
      send(16'hA000);
      run_to(Osr * ClkDiv + 30 * ClkDiv + 1);
      check("hold_full_before_rst", in_ready, 1'b0);
      do_reset(1);
      idle(2 * Osr * ClkDiv);
      check_range("post_rst_ones_f0", window(0, Osr), 32, 32);
      check_range("post_rst_ones_f1", window(Osr, Osr), 32, 32);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, wanted finish before %0t", $time);
      $fatal(1);
   end

endmodule
